// File: rtl/const_rom_arbiter.sv
// Two-requester read arbiter for the shared n_squared/k constant BRAM.
// Define CONST_ROM_ARBITER_FIXED_PRIO_EN to make requester 0 always win contention.
module const_rom_arbiter #(
    parameter int REGISTER_SIZE = 32,
    parameter int NUM_BLOCKS    = 128,
    parameter int MEM_LATENCY   = 2
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic [1:0]                        req_in,
    input  logic [1:0]                        sel_in,
    input  logic [1:0]                        restart_in,
    output logic                              mem_en_out,
    output logic [$clog2(2*NUM_BLOCKS)-1:0]   mem_addr_out,
    input  logic [REGISTER_SIZE-1:0]          mem_data_in,
    output logic [1:0]                        grant_out,
    output logic [REGISTER_SIZE-1:0]          data_out,
    output logic [1:0]                        data_valid_out,
    output logic                              data_last_out,
    output logic [1:0]                        err_out
);

    localparam int AW = $clog2(2*NUM_BLOCKS);
    localparam int IW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

    logic [1:0]               pending;
    logic [1:0]               psel;
    logic [1:0]               err;
    logic [IW-1:0]            idx [2][2];
    logic [AW-1:0]            addr_q;
    logic [REGISTER_SIZE-1:0] data_q;
    logic [1:0]               issue;
    logic                     gid;
    logic [IW-1:0]            cur_idx;
    logic [AW-1:0]            addr_d;
    logic                     last_d;
    logic [1:0]               vld_pipe  [MEM_LATENCY+1];
    logic                     last_pipe [MEM_LATENCY+1];

`ifndef CONST_ROM_ARBITER_FIXED_PRIO_EN
    // Requester favoured on the next contention; flips only when both pend.
    logic prio;
`endif

    always_comb begin
        issue = 2'b00;
`ifdef CONST_ROM_ARBITER_FIXED_PRIO_EN
        if (pending[0])
            issue = 2'b01;
        else if (pending[1])
            issue = 2'b10;
`else
        if (&pending)
            issue = prio ? 2'b10 : 2'b01;
        else
            issue = pending;
`endif
        gid     = issue[1];
        cur_idx = idx[gid][psel[gid]];
        addr_d  = psel[gid] ? AW'(NUM_BLOCKS) + AW'(cur_idx) : AW'(cur_idx);
        last_d  = (cur_idx == IW'(NUM_BLOCKS - 1));
    end

    assign mem_en_out     = |issue;
    assign grant_out      = issue;
    assign mem_addr_out   = mem_en_out ? addr_d : addr_q;
    assign data_out       = data_q;
    assign data_valid_out = vld_pipe[MEM_LATENCY];
    assign data_last_out  = last_pipe[MEM_LATENCY];
    assign err_out        = err;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pending <= 2'b00;
            psel    <= 2'b00;
            err     <= 2'b00;
            addr_q  <= '0;
`ifndef CONST_ROM_ARBITER_FIXED_PRIO_EN
            prio    <= 1'b0;
`endif
            for (int i = 0; i < 2; i++) begin
                idx[i][0] <= '0;
                idx[i][1] <= '0;
            end
        end else begin
            if (mem_en_out)
                addr_q <= addr_d;
`ifndef CONST_ROM_ARBITER_FIXED_PRIO_EN
            if (&pending)
                prio <= ~prio;
`endif
            for (int i = 0; i < 2; i++) begin
                if (issue[i])
                    idx[i][psel[i]] <= (idx[i][psel[i]] == IW'(NUM_BLOCKS - 1))
                                       ? '0 : idx[i][psel[i]] + IW'(1);
                // Restart overrides both the index bump and any new pulse.
                if (restart_in[i]) begin
                    idx[i][0]  <= '0;
                    idx[i][1]  <= '0;
                    pending[i] <= 1'b0;
                end else if (req_in[i]) begin
                    if (pending[i] && !issue[i]) begin
                        err[i] <= 1'b1;
                    end else begin
                        pending[i] <= 1'b1;
                        psel[i]    <= sel_in[i];
                    end
                end else if (issue[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            data_q <= '0;
            for (int k = 0; k <= MEM_LATENCY; k++) begin
                vld_pipe[k]  <= 2'b00;
                last_pipe[k] <= 1'b0;
            end
        end else begin
            vld_pipe[0]  <= issue;
            last_pipe[0] <= last_d & mem_en_out;
            for (int k = 1; k <= MEM_LATENCY; k++) begin
                vld_pipe[k]  <= vld_pipe[k-1];
                last_pipe[k] <= last_pipe[k-1];
            end
            if (|vld_pipe[MEM_LATENCY-1])
                data_q <= mem_data_in;
        end
    end

endmodule
